// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state and grant encodings for the 2:1 packet arbiter
package mux_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} arb_state_e;
   typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;
endpackage

// File: rtl/mux_2x1.sv
// mux_2x1: single-bit 2:1 multiplexer, sel=0 picks a, sel=1 picks b
module mux_2x1 (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic y
);
   assign y = sel ? b : a;
endmodule

// File: rtl/mux_2x1_arbiter.sv
// mux_2x1_arbiter: round-robin packet arbiter steering two valid/ready streams through a bit-sliced 2:1 mux
module mux_2x1_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_last,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_last,
   output logic              b_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              sel,
   output logic              busy,
   output logic              timeout
);
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   arb_state_e        state, state_n;
   grant_e            last_grant, last_grant_n;
   logic              sel_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              own_valid, other_valid, accept, rel;
   logic [DATA_W:0]   a_bus, b_bus, mux_y;
   assign a_bus    = {a_last, a_data};
   assign b_bus    = {b_last, b_data};
   assign out_data = mux_y[DATA_W-1:0];
   assign out_last = mux_y[DATA_W];
   genvar i;
   generate
      for (i = 0; i <= DATA_W; i++) begin : g_mux
         mux_2x1 u_mux (.a(a_bus[i]), .b(b_bus[i]), .sel(sel), .y(mux_y[i]));
      end
   endgenerate
   // handshake outputs, release/timeout detection and next-state selection
   always_comb begin
      busy         = state != IDLE;
      own_valid    = (state == GNT_A && a_valid) || (state == GNT_B && b_valid);
      other_valid  = state == GNT_A ? b_valid : a_valid;
      out_valid    = own_valid;
      a_ready      = state == GNT_A && out_ready;
      b_ready      = state == GNT_B && out_ready;
      accept       = own_valid && out_ready;
      timeout      = TIMEOUT != 0 && busy && !own_valid && cnt == CW'(TIMEOUT);
      rel          = (accept && out_last) || timeout;
      state_n      = state == IDLE ? (a_valid && (!b_valid || last_grant == GRANT_B) ? GNT_A : b_valid ? GNT_B : IDLE)
                   : !rel ? state : !other_valid ? IDLE : state == GNT_A ? GNT_B : GNT_A;
      last_grant_n = rel ? (state == GNT_A ? GRANT_A : GRANT_B) : last_grant;
      sel_n        = state_n == GNT_B ? 1'b1 : state_n == GNT_A ? 1'b0 : sel;
      cnt_n        = (TIMEOUT == 0 || !busy || own_valid || state_n != state) ? '0 : cnt + CW'(1);
   end
   // state, select, round-robin pointer and idle counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= 1'b0;
         last_grant <= GRANT_B;
         cnt        <= '0;
      end else begin
         state      <= state_n;
         sel        <= sel_n;
         last_grant <= last_grant_n;
         cnt        <= cnt_n;
      end
   end
endmodule
